// File: rtl/parking_fee.sv
// Parking fee calculator: tracks per-slot entry times and charges RATE per started hour past a free grace period.
// Optional feature macro PARK_OVERNIGHT_EN: exits earlier in the day than their entry are billed across midnight.
module parking_fee #(
  parameter int SLOT_W   = 3,
  parameter int RATE     = 5,
  parameter int FREE_MIN = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           hour,
  input  logic [5:0]           minute,
  input  logic                 enter,
  input  logic                 exit,
  input  logic [SLOT_W-1:0]    slot,
  output logic                 fee_valid,
  input  logic                 fee_ready,
  output logic [11:0]          fee,
  output logic [10:0]          duration,
  output logic [SLOT_W-1:0]    fee_slot,
  output logic                 busy,
  output logic                 err,
  output logic [2**SLOT_W-1:0] occupied
);

  localparam int SLOTS = 2**SLOT_W;
  localparam logic [10:0] FREE_W = 11'(FREE_MIN);
  localparam logic [11:0] RATE_W = 12'(RATE);

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t      state, state_next;
  logic [10:0] entry [SLOTS];
  logic [10:0] rem;
  logic [4:0]  hrs;
  logic [10:0] now;
  logic [10:0] entry_sel;
  logic [10:0] dur_calc;
  logic        is_occ;
  logic        wrap;
  logic        do_enter, do_exit, do_drop, err_next;

  assign now       = 11'(hour) * 11'd60 + 11'(minute);
  assign entry_sel = entry[slot];
  assign is_occ    = occupied[slot];
  assign wrap      = now < entry_sel;

`ifdef PARK_OVERNIGHT_EN
  assign dur_calc = wrap ? 11'(12'(now) + 12'd1440 - 12'(entry_sel)) : now - entry_sel;
`else
  assign dur_calc = now - entry_sel;
`endif

  assign fee_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Events are only honoured in IDLE; anything else is flagged and ignored.
  always_comb begin
    state_next = state;
    do_enter   = 1'b0;
    do_exit    = 1'b0;
    do_drop    = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (enter && exit) begin
          err_next = 1'b1;
        end else if (enter) begin
          if (is_occ) err_next = 1'b1;
          else        do_enter = 1'b1;
        end else if (exit) begin
          if (!is_occ) begin
            err_next = 1'b1;
          end else begin
`ifndef PARK_OVERNIGHT_EN
            if (wrap) begin
              do_drop  = 1'b1;
              err_next = 1'b1;
            end else
`endif
            begin
              do_exit    = 1'b1;
              state_next = SUB;
            end
          end
        end
      end
      SUB: begin
        if (rem == 11'd0) state_next = DONE;
        if (enter || exit) err_next = 1'b1;
      end
      DONE: begin
        if (fee_ready) state_next = IDLE;
        if (enter || exit) err_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Hours are counted by repeated subtraction of 60 so no divider is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupied <= '0;
      for (int i = 0; i < SLOTS; i++) entry[i] <= '0;
      fee      <= '0;
      duration <= '0;
      fee_slot <= '0;
      hrs      <= '0;
      rem      <= '0;
      err      <= 1'b0;
    end else begin
      err <= err_next;
      if (do_enter) begin
        occupied[slot] <= 1'b1;
        entry[slot]    <= now;
      end
      if (do_drop) occupied[slot] <= 1'b0;
      if (do_exit) begin
        occupied[slot] <= 1'b0;
        fee_slot       <= slot;
        duration       <= dur_calc;
        rem            <= dur_calc;
        hrs            <= '0;
      end
      if (state == SUB) begin
        if (rem == 11'd0) begin
          fee <= (duration < FREE_W) ? 12'd0 : 12'(hrs) * RATE_W;
        end else begin
          rem <= (rem >= 11'd60) ? rem - 11'd60 : 11'd0;
          hrs <= hrs + 5'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_parking_fee.sv
// Directed bench for parking_fee (RATE=5, FREE_MIN=15, SLOT_W=3); expectations hand-computed.
module tb_parking_fee;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hour, minute;
  logic        enter, exit;
  logic [2:0]  slot;
  logic        fee_valid, fee_ready;
  logic [11:0] fee;
  logic [10:0] duration;
  logic [2:0]  fee_slot;
  logic        busy, err;
  logic [7:0]  occupied;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  parking_fee #(.SLOT_W(3), .RATE(5), .FREE_MIN(15)) dut (
    .clk(clk), .reset(reset), .hour(hour), .minute(minute),
    .enter(enter), .exit(exit), .slot(slot),
    .fee_valid(fee_valid), .fee_ready(fee_ready), .fee(fee),
    .duration(duration), .fee_slot(fee_slot),
    .busy(busy), .err(err), .occupied(occupied)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one strobe cycle; returns at the negedge after the sampling edge.
  task automatic applyStimulus(input logic en, input logic ex, input logic [2:0] s,
                               input logic [5:0] h, input logic [5:0] m);
    @(negedge clk);
    enter = en; exit = ex; slot = s; hour = h; minute = m;
    @(negedge clk);
    enter = 1'b0; exit = 1'b0;
  endtask

  task automatic waitFee(output int cycles);
    cycles = 0;
    while (!fee_valid && cycles < 50) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic acceptFee;
    @(negedge clk);
    fee_ready = 1'b1;
    @(negedge clk);
    fee_ready = 1'b0;
  endtask

  initial begin
    int cycles;
    reset = 1'b1; enter = 1'b0; exit = 1'b0; slot = '0;
    hour = '0; minute = '0; fee_ready = 1'b0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", fee_valid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_occ", occupied, 0);
    checkOutput("rst_fee", fee, 0);
    checkOutput("rst_dur", duration, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Slot 2: 08:10 -> 10:25, 135 min, 3 started hours
    applyStimulus(1, 0, 2, 8, 10);
    checkOutput("s2_enter_err", err, 0);
    checkOutput("s2_enter_occ", occupied, 8'h04);
    applyStimulus(0, 1, 2, 10, 25);
    checkOutput("s2_exit_err", err, 0);
    checkOutput("s2_exit_busy", busy, 1);
    checkOutput("s2_exit_occ", occupied, 0);
    waitFee(cycles);
    checkOutput("s2_latency", cycles, 4);
    checkOutput("s2_fee", fee, 15);
    checkOutput("s2_dur", duration, 135);
    checkOutput("s2_slot", fee_slot, 2);
    acceptFee();
    checkOutput("s2_idle", busy, 0);
    checkOutput("s2_valid_low", fee_valid, 0);
    checkOutput("s2_fee_hold", fee, 15);
    checkOutput("s2_dur_hold", duration, 135);

    // Slot 0: 10 minutes is inside the grace period
    applyStimulus(1, 0, 0, 8, 10);
    applyStimulus(0, 1, 0, 8, 20);
    waitFee(cycles);
    checkOutput("s0_latency", cycles, 2);
    checkOutput("s0_fee", fee, 0);
    checkOutput("s0_dur", duration, 10);
    acceptFee();

    // Same-minute exit
    applyStimulus(1, 0, 0, 9, 0);
    applyStimulus(0, 1, 0, 9, 0);
    waitFee(cycles);
    checkOutput("zero_latency", cycles, 1);
    checkOutput("zero_fee", fee, 0);
    checkOutput("zero_dur", duration, 0);
    acceptFee();

    // Slot 5 across midnight: 23:50 -> 00:40
    applyStimulus(1, 0, 5, 23, 50);
    checkOutput("s5_occ", occupied, 8'h20);
    applyStimulus(0, 1, 5, 0, 40);
`ifdef PARK_OVERNIGHT_EN
    checkOutput("s5_err", err, 0);
    waitFee(cycles);
    checkOutput("s5_latency", cycles, 2);
    checkOutput("s5_fee", fee, 5);
    checkOutput("s5_dur", duration, 50);
    checkOutput("s5_slot", fee_slot, 5);
    acceptFee();
`else
    checkOutput("s5_err", err, 1);
    checkOutput("s5_busy", busy, 0);
    checkOutput("s5_occ_clr", occupied, 0);
    @(negedge clk);
    checkOutput("s5_err_pulse", err, 0);
    repeat (5) @(negedge clk);
    checkOutput("s5_no_valid", fee_valid, 0);
`endif

    // Illegal events: slot 2 entered at 07:00, then three rejected strobes
    applyStimulus(1, 0, 2, 7, 0);
    checkOutput("ill_occ", occupied, 8'h04);
    applyStimulus(0, 1, 3, 7, 10);
    checkOutput("ill_exitfree_err", err, 1);
    checkOutput("ill_exitfree_occ", occupied, 8'h04);
    @(negedge clk);
    checkOutput("ill_err_drop1", err, 0);
    applyStimulus(1, 0, 2, 8, 30);
    checkOutput("ill_reenter_err", err, 1);
    checkOutput("ill_reenter_occ", occupied, 8'h04);
    @(negedge clk);
    checkOutput("ill_err_drop2", err, 0);
    applyStimulus(1, 1, 1, 8, 40);
    checkOutput("ill_both_err", err, 1);
    checkOutput("ill_both_occ", occupied, 8'h04);
    checkOutput("ill_both_busy", busy, 0);

    // Exit slot 2 at 09:00: 120 min from the original 07:00 entry; time moves mid-compute
    applyStimulus(0, 1, 2, 9, 0);
    hour = 6'd20; minute = 6'd45;
    waitFee(cycles);
    checkOutput("hold_latency", cycles, 3);
    checkOutput("hold_fee0", fee, 10);
    repeat (2) @(negedge clk);
    applyStimulus(1, 0, 6, 12, 0);
    checkOutput("hold_err", err, 1);
    checkOutput("hold_no_store", occupied, 0);
    @(negedge clk);
    checkOutput("hold_fee", fee, 10);
    checkOutput("hold_dur", duration, 120);
    checkOutput("hold_slot", fee_slot, 2);
    checkOutput("hold_valid", fee_valid, 1);
    acceptFee();
    checkOutput("hold_idle", busy, 0);

    // Reset during SUB: slot 7 parked, slot 1 exits after 240 min
    applyStimulus(1, 0, 7, 0, 30);
    applyStimulus(1, 0, 1, 1, 0);
    applyStimulus(0, 1, 1, 5, 0);
    checkOutput("rsub_busy", busy, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("rsub_busy0", busy, 0);
    checkOutput("rsub_valid0", fee_valid, 0);
    checkOutput("rsub_occ0", occupied, 0);
    checkOutput("rsub_fee0", fee, 0);
    checkOutput("rsub_dur0", duration, 0);
    checkOutput("rsub_slot0", fee_slot, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    checkOutput("rsub_no_fee", fee_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parking_fee.md
PARKING_FEE -- requirements
Module: parking_fee

Interface
REQ-001 SHALL have parameter SLOT_W, default 3, slot index width; slot count SLOTS = 2**SLOT_W.
REQ-002 SHALL have parameter RATE, default 5, fee units per started hour; legal range 1..170.
REQ-003 SHALL have parameter FREE_MIN, default 15, minutes of free grace; legal range 0..1439.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports hour  in  6  (0..23) and minute  in  6  (0..59), the current time of day from the upstream timer.
REQ-007 SHALL have ports enter  in  1, exit  in  1  (one-cycle event strobes) and slot  in  SLOT_W  (slot addressed by the strobe).
REQ-008 SHALL have ports fee_valid  out  1, fee_ready  in  1, fee  out  12, duration  out  11 (minutes), and fee_slot  out  SLOT_W.
REQ-009 SHALL have ports busy  out  1, err  out  1 (one-cycle pulse), and occupied  out  SLOTS (bit i set = slot i in use).

Function
REQ-010 SHALL sample now = hour*60+minute (11 bits) on every accepted event.
REQ-011 SHALL have FSM states IDLE, SUB, DONE; events SHALL be accepted only in IDLE; busy = (state != IDLE).
REQ-012 Enter on a free slot in IDLE SHALL store now as that slot's entry time and set occupied[slot] the next cycle.
REQ-013 Enter on an occupied slot, exit on a free slot, any event outside IDLE, or enter and exit in the same cycle SHALL pulse err for one cycle and change no state.
REQ-014 Accepted exit SHALL clear occupied[slot], latch fee_slot, and compute duration = now - entry (11-bit result; wrap rule per REQ-022); the FSM SHALL enter SUB with rem = duration and hrs = 0.
REQ-015 In SUB, each cycle: if rem == 0, go to DONE; otherwise rem = (rem >= 60) ? rem-60 : 0 and hrs = hrs+1. SUB therefore lasts ceil(duration/60)+1 cycles.
REQ-016 On entering DONE: fee = (duration < FREE_MIN) ? 0 : hrs*RATE, and fee_valid = 1.
REQ-017 In DONE, fee, duration and fee_slot SHALL be held stable while fee_ready = 0.
REQ-018 When fee_valid & fee_ready, the FSM SHALL return to IDLE the next cycle with fee_valid = 0; fee and duration SHALL hold their last values.
REQ-019 duration == 0 (exit in the same minute as entry) SHALL give fee 0; a full 24 h stay aliases to duration 0 by design.
REQ-020 Time changes while in SUB or DONE SHALL have no effect on the computation in progress.

Reset
REQ-021 When reset is asserted, the block SHALL immediately force: state IDLE; occupied, all entry times, fee, duration, fee_slot, hrs and rem to 0; and fee_valid, err and busy to 0. A computation in flight SHALL be aborted with no fee output.

Configuration
REQ-022 Macro PARK_OVERNIGHT_EN: when defined, an exit with now < entry SHALL use duration = now + 1440 - entry.
REQ-023 When PARK_OVERNIGHT_EN is undefined, an exit with now < entry SHALL clear occupied[slot], pulse err, stay in IDLE, and produce no fee.

Verification (RATE=5, FREE_MIN=15, SLOT_W=3)
REQ-024 enter slot 2 at 08:10, exit at 10:25 -> duration 135, fee 15, fee_slot 2, fee_valid 4 cycles after exit, occupied[2] = 0.
REQ-025 enter slot 0 at 08:10, exit at 08:20 -> duration 10, fee 0; exit in the same minute as entry -> duration 0, fee 0.
REQ-026 enter slot 5 at 23:50, exit at 00:40 -> with macro: duration 50, fee 5; without macro: err pulse, no fee_valid, occupied[5] = 0.
REQ-027 exit on free slot 3; enter on occupied slot 2; enter and exit in the same cycle -> one err pulse each, occupied unchanged, no fee_valid.
REQ-028 hold fee_ready = 0 for 5 cycles in DONE and strobe enter -> fee stable, err pulses, no store; raise fee_ready -> IDLE next cycle. reset asserted during SUB -> all outputs 0 at once.
